// File: rtl/store_rmw_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_rmw_unit_pkg
//   Shared definitions for the store read-modify-write path:
//     - default data/address widths of the RV32I core
//     - store func3 codes (sb/sh/sw), which sit beside the load func3 codes
//     - FSM state encoding of store_rmw_unit
//     - is_store_func3(): legality check of a store func3 code
// -----------------------------------------------------------------------------
package store_rmw_unit_pkg;

  localparam int unsigned RV_DATA_WIDTH = 32;
  localparam int unsigned RV_ADDR_WIDTH = 32;

  // Store func3 codes.
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } rmw_state_e;

  function automatic logic is_store_func3(input logic [2:0] func3);
    return (func3 == F3_SB) || (func3 == F3_SH) || (func3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_rmw_unit_aligner.sv
// -----------------------------------------------------------------------------
// store_aligner
//   Purely combinational store lane logic. Works out which byte lanes a store
//   writes, replicates the store data across the lanes, and merges it with the
//   word read back from memory. Kept free of any sequencing so that a
//   byte-enable memory variant can use byte_mask_o and wdata_o directly.
//
//   Ports:
//     func3_i      store func3 (sb/sh/sw); other codes give an empty mask
//     addr_i       byte offset within the word (addr[1:0])
//     data_i       rs2 value, right-aligned
//     rdata_i      current memory word (old contents)
//     byte_mask_o  lanes written by this store
//     wdata_o      merged word: new bytes in masked lanes, old bytes elsewhere
//     misaligned_o sh on an odd address, or sw not on a word boundary
// -----------------------------------------------------------------------------
module store_aligner
  import store_rmw_unit_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_mask_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  logic [31:0] lane_data;

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned infers a latch.
  always_comb begin
    byte_mask_o  = 4'b0000;
    lane_data    = 32'h0;
    misaligned_o = 1'b0;
    unique case (func3_i)
      F3_SB: begin
        byte_mask_o = 4'b0001 << addr_i;
        lane_data   = {4{data_i[7:0]}};
      end
      F3_SH: begin
        byte_mask_o  = 4'b0011 << {addr_i[1], 1'b0};
        lane_data    = {2{data_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      F3_SW: begin
        byte_mask_o  = 4'b1111;
        lane_data    = data_i;
        misaligned_o = |addr_i;
      end
      default: ;
    endcase
  end

  // Lane merge: replicated new data where the mask is set, old data elsewhere.
  always_comb begin
    wdata_o = rdata_i;
    for (int i = 0; i < 4; i++) begin
      if (byte_mask_o[i]) wdata_o[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
//   Writes decoded stores (sb/sh/sw) into a data BRAM that has a single
//   whole-word write enable. Sub-word stores are done as read-modify-write:
//   read the word, merge the new bytes, write it back. Full-word stores skip
//   the read. Misaligned addresses and illegal func3 codes fault without any
//   BRAM access.
//
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     req_valid     store request present
//     req_ready     high only in IDLE and not in reset
//     req_addr      byte address
//     req_data      rs2 value, right-aligned
//     req_func3     000 = sb, 001 = sh, 010 = sw
//     done          one-cycle pulse when the store completes or faults
//     fault         qualified by done: misaligned or illegal func3
//     byte_mask     lanes written by the current store (trace)
//     bram_en       BRAM port enable
//     bram_we       BRAM write enable (whole word)
//     bram_addr     word address (req_addr[ADDR_WIDTH-1:2])
//     bram_wdata    merged write word, driven in the write cycle only
//     bram_rdata    BRAM read data, valid READ_LATENCY cycles after bram_en
//
//   Sequence: IDLE -> RD -> RD_WAIT (READ_LATENCY cycles) -> WR -> RESP for
//   sb/sh, IDLE -> WR -> RESP for sw, IDLE -> RESP for a fault.
//   Only DATA_WIDTH = 32 is supported; READ_LATENCY must be 1..3.
// -----------------------------------------------------------------------------
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = RV_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = RV_DATA_WIDTH,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [2:0]            req_func3,
  output logic                  done,
  output logic                  fault,
  output logic [3:0]            byte_mask,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-3:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  // Index of the RD_WAIT cycle on which bram_rdata is valid.
  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  rmw_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            func3_q, func3_d;
  logic                  fault_q, fault_d;
  logic [3:0]            mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            wait_q, wait_d;

  // Single aligner instance: in IDLE it looks at the incoming request so the
  // accept-time checks and mask come from the same logic that later builds
  // the merged word from the latched request and the captured read data.
  logic                  in_idle;
  logic [2:0]            al_func3;
  logic [1:0]            al_addr;
  logic [DATA_WIDTH-1:0] al_data;
  logic [3:0]            al_mask;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic                  al_misaligned;
  logic                  accept;
  logic                  accept_fault;

  assign in_idle  = (state_q == ST_IDLE);
  assign al_func3 = in_idle ? req_func3     : func3_q;
  assign al_addr  = in_idle ? req_addr[1:0] : addr_q[1:0];
  assign al_data  = in_idle ? req_data      : data_q;

  store_aligner u_aligner (
    .func3_i      (al_func3),
    .addr_i       (al_addr),
    .data_i       (al_data),
    .rdata_i      (rdata_q),
    .byte_mask_o  (al_mask),
    .wdata_o      (al_wdata),
    .misaligned_o (al_misaligned)
  );

  assign req_ready    = in_idle && !rst;
  assign accept       = req_valid && req_ready;
  assign accept_fault = !is_store_func3(req_func3) || al_misaligned;

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    func3_d = func3_q;
    fault_d = fault_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          data_d  = req_data;
          func3_d = req_func3;
          fault_d = accept_fault;
          mask_d  = al_mask;
          if (accept_fault)             state_d = ST_RESP;
          else if (req_func3 == F3_SW)  state_d = ST_WR;
          else                          state_d = ST_RD;
        end
      end
      ST_RD: begin
        wait_d  = 2'd0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_q == LAST_WAIT) begin
          rdata_d = bram_rdata;
          state_d = ST_WR;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_WR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        mask_d  = 4'b0000;
        fault_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      func3_q <= 3'b000;
      fault_q <= 1'b0;
      mask_q  <= 4'b0000;
      rdata_q <= '0;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      func3_q <= func3_d;
      fault_q <= fault_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decode directly from registered state, so a reset mid-sequence
  // drops the BRAM strobes in the same instant.
  assign done       = (state_q == ST_RESP);
  assign fault      = (state_q == ST_RESP) && fault_q;
  assign byte_mask  = mask_q;
  assign bram_en    = (state_q == ST_RD) || (state_q == ST_WR);
  assign bram_we    = (state_q == ST_WR);
  assign bram_addr  = addr_q[ADDR_WIDTH-1:2];
  assign bram_wdata = (state_q == ST_WR) ? al_wdata : '0;

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load path: takes a decoded store (sb/sh/sw) and writes it into the data BRAM.
- The data BRAM has one write enable and no byte enables. Sub-word stores are therefore done as read-modify-write: read the word, merge the new bytes, write it back.
- Sits between the execute stage and the data BRAM write port. It shares the port with the load path; arbitration happens outside this block.
- Handshake is valid/ready on the request side and a one-cycle done/fault pulse on the response side.

Parameters:
- ADDR_WIDTH, 32, byte address width of the request.
- DATA_WIDTH, 32, word width. Only 32 is supported.
- READ_LATENCY, 1, cycles from a BRAM read enable to valid bram_rdata (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  high only in IDLE and not in reset.
- req_addr  in  ADDR_WIDTH  byte address.
- req_data  in  DATA_WIDTH  rs2 value, right-aligned.
- req_func3  in  3  000 = sb, 001 = sh, 010 = sw.
- done  out  1  one-cycle pulse when the store completes or faults.
- fault  out  1  valid with done: misaligned address or illegal func3.
- byte_mask  out  4  lanes written by the current store (debug/trace).
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable (whole word).
- bram_addr  out  ADDR_WIDTH-2  word address, req_addr[ADDR_WIDTH-1:2].
- bram_wdata  out  DATA_WIDTH  merged write word.
- bram_rdata  in  DATA_WIDTH  BRAM read data.

Behaviour:
- Reset: state = IDLE. done, fault, bram_en, bram_we are 0. byte_mask, bram_addr, bram_wdata are all zero. req_ready is 0 while rst is high. Reset takes effect immediately in any state, including mid-read-modify-write; the partial write is abandoned.
- Accept: req_valid && req_ready at edge T. addr, data and func3 are latched at T. Request inputs are ignored outside IDLE.
- Checks at accept:
  - func3 outside {000, 001, 010} is a fault.
  - sh with addr[0] = 1 is a fault.
  - sw with addr[1:0] != 0 is a fault.
- Byte mask:
  - sb: 4'b0001 << addr[1:0].
  - sh: 4'b0011 << {addr[1], 1'b0}.
  - sw: 4'b1111.
- Lane data: sb replicates data[7:0] into all 4 lanes; sh replicates data[15:0] into 2 lanes; sw uses data as-is.
- Merge: for each lane i, wdata lane i = byte_mask[i] ? lane data : bram_rdata lane i.
- States: IDLE, RD, RD_WAIT, WR, RESP.
  - IDLE -> RESP on a faulting request. No BRAM access is made.
  - IDLE -> WR on sw, which skips the read.
  - IDLE -> RD on sb/sh.
  - RD: bram_en = 1, bram_we = 0 for one cycle, then RD_WAIT.
  - RD_WAIT: stays READ_LATENCY cycles and captures bram_rdata on its last cycle, then WR.
  - WR: bram_en = 1, bram_we = 1, bram_wdata = merged word, for one cycle, then RESP.
  - RESP: done = 1, fault as computed. Returns to IDLE the next cycle.
- Latency from the accept edge T to the done cycle:
  - sw: 2 cycles (WR at T+1, done at T+2).
  - sb/sh: 3 + READ_LATENCY cycles.
  - fault: 1 cycle.
- Throughput: the next accept is possible in the cycle after RESP. There are no back-to-back accepts.
- bram_addr is held stable from RD through WR. bram_en/bram_we are 0 in IDLE, RD_WAIT and RESP.
- byte_mask is valid from the cycle after accept through RESP, and is cleared to zero in IDLE.
- Address wrap-around: the word address is truncated to ADDR_WIDTH-2 bits. No bound check is made.

Decomposition:
- rv32i_params.vh: DATA_WIDTH, ADDR_WIDTH.
- rv32i_control.vh: add F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010 beside the existing load func3 codes. Add the state encoding localparams there or local to the block.
- One combinational sub-module, store_aligner:
  - Inputs: func3, addr[1:0], data, rdata.
  - Outputs: byte_mask, merged wdata, misaligned.
  - Reusable by a future byte-enable BRAM variant.

Test Plan:
- sw addr = 0x0000_0010, data = 0xDEADBEEF:
  - no read cycle; WR at T+1 with bram_addr = 0x4, bram_wdata = 0xDEADBEEF, bram_we = 1;
  - done at T+2, fault = 0, byte_mask = 4'b1111.
- sb addr = 0x13, data = 0x0000_00A5, BRAM word = 0x11223344:
  - RD then RD_WAIT;
  - WR bram_wdata = 0xA5223344, byte_mask = 4'b1000, done at T+4.
- sh addr = 0x2, data = 0x0000_BEEF, BRAM word = 0x11223344 -> WR bram_wdata = 0xBEEF3344, byte_mask = 4'b1100.
- Fault cases, each must give done = 1 and fault = 1 at T+1 with bram_en never asserted:
  - sh at addr = 0x1;
  - sw at addr = 0x2;
  - func3 = 3'b011.
- Reset mid-op: assert rst during RD_WAIT of an sb. bram_en/bram_we must drop immediately, no WR cycle may occur, done must stay 0, and req_ready must be 1 in the first cycle after rst deasserts.
- READ_LATENCY = 3, sb addr = 0x0 -> done exactly 6 cycles after accept; merged lane 0 only.
